// File: rtl/moore_seq_pkg.sv
// Shared types and sizes for the Moore serial pattern generator.
package moore_seq_pkg;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned PAT_W   = MAX_LEN;
    localparam int unsigned LEN_W   = 4;
    localparam int unsigned REPS_W  = 4;
    localparam int unsigned GAP_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Request captured when a transfer is accepted
    typedef struct packed {
        logic [PAT_W-1:0] pattern;
        logic [LEN_W-1:0] len;
    } req_t;

    // A length is usable only in 1..MAX_LEN
    function automatic logic len_ok(input logic [LEN_W-1:0] len_i);
        return (len_i != '0) && (len_i <= LEN_W'(MAX_LEN));
    endfunction

endpackage

// File: rtl/seq_shift_reg.sv
// Load/shift-left register; a loaded pattern is left-aligned so bit len-1
// lands in the top bit, which is then always the bit on the wire.
// Zero fill means the register drains to 0 after the last bit.
module seq_shift_reg
    import moore_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [PAT_W-1:0] data_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             msb_o
);

    logic [PAT_W-1:0] sh_q;
    logic [PAT_W-1:0] sh_d;
    logic [LEN_W-1:0] align;

    // Next value: aligned load has priority over a single-bit shift
    always_comb begin
        align = LEN_W'(MAX_LEN) - len_i;
        sh_d  = sh_q;
        if (load_i) begin
            sh_d = data_i << align;
        end else if (shift_i) begin
            sh_d = {sh_q[PAT_W-2:0], 1'b0};
        end
    end

    // Register with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign msb_o = sh_q[PAT_W-1];

endmodule

// File: rtl/moore_seq_gen.sv
// Moore serial pattern generator: sends an MSB-first pattern reps+1 times,
// optionally separated by GAP_CYCLES idle cycles, then pulses done.
module moore_seq_gen
    import moore_seq_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PAT_W-1:0]  pattern,
    input  logic [LEN_W-1:0]  len,
    input  logic [REPS_W-1:0] reps,
    output logic              dout,
    output logic              dvalid,
    output logic              busy,
    output logic              done
);

    state_e            state_q, state_d;
    req_t              cfg_q, cfg_d;
    logic [LEN_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [REPS_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic              dvalid_q, dvalid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              sh_load;
    logic              sh_shift;
    logic [PAT_W-1:0]  sh_data;
    logic [LEN_W-1:0]  sh_len;
    logic              sh_msb;

    seq_shift_reg u_shift (
        .clk     (clk),
        .rst     (rst),
        .load_i  (sh_load),
        .shift_i (sh_shift),
        .data_i  (sh_data),
        .len_i   (sh_len),
        .msb_o   (sh_msb)
    );

    // Next-state, counter and shifter-control logic; flags follow next state
    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        bit_cnt_d = bit_cnt_q;
        rep_cnt_d = rep_cnt_q;
        gap_cnt_d = gap_cnt_q;
        sh_load   = 1'b0;
        sh_shift  = 1'b0;
        sh_data   = cfg_q.pattern;
        sh_len    = cfg_q.len;

        case (state_q)
            IDLE: begin
                if (start && len_ok(len)) begin
                    state_d       = SEND;
                    cfg_d.pattern = pattern;
                    cfg_d.len     = len;
                    bit_cnt_d     = len - LEN_W'(1);
                    rep_cnt_d     = reps;
                    sh_load       = 1'b1;
                    sh_data       = pattern;
                    sh_len        = len;
                end
            end
            SEND: begin
                if (bit_cnt_q == '0) begin
                    if (rep_cnt_q == '0) begin
                        state_d  = DONE;
                        sh_shift = 1'b1;
                    end else begin
                        rep_cnt_d = rep_cnt_q - REPS_W'(1);
                        if (GAP_CYCLES > 0) begin
                            state_d   = GAP;
                            gap_cnt_d = GAP_W'(GAP_CYCLES - 1);
                            sh_shift  = 1'b1;
                        end else begin
                            bit_cnt_d = cfg_q.len - LEN_W'(1);
                            sh_load   = 1'b1;
                        end
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - LEN_W'(1);
                    sh_shift  = 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d   = SEND;
                    bit_cnt_d = cfg_q.len - LEN_W'(1);
                    sh_load   = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        dvalid_d = (state_d == SEND);
        busy_d   = (state_d == SEND) || (state_d == GAP);
        done_d   = (state_d == DONE);
    end

    // State, counters, latched request and output flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cfg_q     <= '0;
            bit_cnt_q <= '0;
            rep_cnt_q <= '0;
            gap_cnt_q <= '0;
            dvalid_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            bit_cnt_q <= bit_cnt_d;
            rep_cnt_q <= rep_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            dvalid_q  <= dvalid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign dout   = sh_msb;
    assign dvalid = dvalid_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
